// File: rtl/pixel_effect_stage_if.sv
// Avalon-ST style RGB444 pixel stream: SOP/EOP framed beats with valid/ready handshake.
interface pixel_effect_stage_if;
    logic [11:0] data;
    logic        sop;
    logic        eop;
    logic        valid;
    logic        ready;

    modport master (output data, output sop, output eop, output valid, input ready);
    modport slave  (input data, input sop, input eop, input valid, output ready);
endinterface

// File: rtl/pixel_effect_stage.sv
// Two-stage colour-effect pipeline (pass/invert/greyscale/threshold) on an RGB444 stream.
// Define PIXEL_EFFECT_FRAME_CHECK_EN to enable the framing checker that repairs malformed frames.
module pixel_effect_stage #(
    parameter int unsigned NumPixels     = 320 * 240,
    parameter int unsigned NumColourBits = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_effect_stage_if.slave  in_s,
    pixel_effect_stage_if.master out_s,
    input  logic [1:0]           effect_sel,
    input  logic [3:0]           threshold,
    output logic                 frame_error,
    output logic [15:0]          frame_count
);
    logic                     s1_valid_q, s1_sop_q, s1_eop_q;
    logic [NumColourBits-1:0] s1_data_q;
    logic [3:0]               s1_y_q, s1_thr_q;
    logic [1:0]               s1_eff_q;
    logic                     s2_valid_q, s2_sop_q, s2_eop_q;
    logic [NumColourBits-1:0] s2_data_q;
    logic [1:0]               eff_q;
    logic [3:0]               thr_q;
    logic                     frame_error_q;
    logic [15:0]              frame_count_q;

    logic                     s1_en, s2_en, accept;
    logic                     fwd, fwd_eop, err;
    logic [7:0]               y_sum;
    logic [3:0]               y_in, thr_cur;
    logic [1:0]               eff_cur;
    logic [NumColourBits-1:0] fx_data;

    assign s2_en  = !s2_valid_q || out_s.ready;
    assign s1_en  = !s1_valid_q || s2_en;
    assign accept = in_s.valid && s1_en;

    // Effect settings travel with each beat so a new frame can enter while the old one drains.
    assign eff_cur = (accept && in_s.sop) ? effect_sel : eff_q;
    assign thr_cur = (accept && in_s.sop) ? threshold  : thr_q;

    assign y_sum = 8'd5 * {4'd0, in_s.data[11:8]} + 8'd9 * {4'd0, in_s.data[7:4]}
                 + 8'd2 * {4'd0, in_s.data[3:0]};
    assign y_in  = 4'(y_sum >> 4);

    always_comb begin
        fx_data = s1_data_q;
        unique case (s1_eff_q)
            2'd0:    fx_data = s1_data_q;
            2'd1:    fx_data = 12'hFFF - s1_data_q;
            2'd2:    fx_data = {3{s1_y_q}};
            default: fx_data = (s1_y_q >= s1_thr_q) ? 12'hFFF : 12'h000;
        endcase
    end

`ifdef PIXEL_EFFECT_FRAME_CHECK_EN
    localparam int unsigned       CntW    = $clog2(NumPixels) + 1;
    localparam logic [CntW-1:0]   LastIdx = CntW'(NumPixels - 1);
    localparam logic              Multi   = (NumPixels != 1);

    typedef enum logic [0:0] {StIdle, StInFrame} state_e;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fwd     = 1'b1;
        fwd_eop = in_s.eop;
        err     = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!in_s.sop) begin
                        fwd = 1'b0;
                        err = 1'b1;
                    end else if (in_s.eop) begin
                        err = Multi;
                    end else begin
                        state_d = StInFrame;
                        cnt_d   = CntW'(1);
                    end
                end
                StInFrame: begin
                    if (in_s.sop) begin
                        err = 1'b1;
                        if (in_s.eop) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = CntW'(1);
                        end
                    end else if (in_s.eop) begin
                        err     = (cnt_q != LastIdx);
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == LastIdx) begin
                        // Over-long frame: close it here so the sink never sees a runaway frame.
                        fwd_eop = 1'b1;
                        err     = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end
`else
    assign fwd     = 1'b1;
    assign fwd_eop = in_s.eop;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_sop_q      <= 1'b0;
            s1_eop_q      <= 1'b0;
            s1_data_q     <= '0;
            s1_y_q        <= '0;
            s1_eff_q      <= '0;
            s1_thr_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_sop_q      <= 1'b0;
            s2_eop_q      <= 1'b0;
            s2_data_q     <= '0;
            eff_q         <= '0;
            thr_q         <= '0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (accept && in_s.sop) begin
                eff_q <= effect_sel;
                thr_q <= threshold;
            end
            if (s1_en) begin
                s1_valid_q <= accept && fwd;
                if (accept) begin
                    s1_data_q <= in_s.data;
                    s1_sop_q  <= in_s.sop;
                    s1_eop_q  <= fwd_eop;
                    s1_y_q    <= y_in;
                    s1_eff_q  <= eff_cur;
                    s1_thr_q  <= thr_cur;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= fx_data;
                    s2_sop_q  <= s1_sop_q;
                    s2_eop_q  <= s1_eop_q;
                end
            end
            frame_error_q <= accept && err;
            if (s2_valid_q && out_s.ready && s2_eop_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign in_s.ready  = s1_en;
    assign out_s.valid = s2_valid_q;
    assign out_s.data  = s2_data_q;
    assign out_s.sop   = s2_sop_q;
    assign out_s.eop   = s2_eop_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_pixel_effect_stage.sv
// Scoreboard bench for pixel_effect_stage with NumPixels=16; adapts to PIXEL_EFFECT_FRAME_CHECK_EN.
`timescale 1ns/1ps
module tb_pixel_effect_stage;
    localparam int unsigned NumPixels = 16;
`ifdef PIXEL_EFFECT_FRAME_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  effect_sel = 2'd0;
    logic [3:0]  threshold = 4'd0;
    logic        frame_error;
    logic [15:0] frame_count;

    pixel_effect_stage_if in_if ();
    pixel_effect_stage_if out_if ();

    pixel_effect_stage #(
        .NumPixels    (NumPixels),
        .NumColourBits(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_s       (in_if),
        .out_s      (out_if),
        .effect_sel (effect_sel),
        .threshold  (threshold),
        .frame_error(frame_error),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t mon_exp;
    beat_t held;
    bit    stalled = 1'b0;
    bit    bp_en = 1'b0;
    int    err_cycles = 0;
    int    out_beats = 0;
    int    exp_frames = 0;
    logic [1:0] tb_eff = 2'd0;
    logic [3:0] tb_thr = 4'd0;

    function automatic logic [11:0] model_fx(logic [11:0] p, logic [1:0] m, logic [3:0] t);
        int y;
        y = (5 * p[11:8] + 9 * p[7:4] + 2 * p[3:0]) / 16;
        case (m)
            2'd0:    return p;
            2'd1:    return 12'hFFF - p;
            2'd2:    return {y[3:0], y[3:0], y[3:0]};
            default: return (y >= int'(t)) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on each transfer, hold check while stalled.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_error === 1'b1) err_cycles++;
            if (stalled) begin
                checks++;
                if (out_if.valid !== 1'b1 || out_if.data !== held.data ||
                    out_if.sop !== held.sop || out_if.eop !== held.eop) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h s=%b e=%b, want v=1 d=%h s=%b e=%b",
                             out_if.valid, out_if.data, out_if.sop, out_if.eop,
                             held.data, held.sop, held.eop);
                end
            end
            stalled = 1'b0;
            if (out_if.valid === 1'b1) begin
                if (out_if.ready === 1'b1) begin
                    out_beats++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_beat: got unexpected d=%h s=%b e=%b, want no beat",
                                 out_if.data, out_if.sop, out_if.eop);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (out_if.data !== mon_exp.data || out_if.sop !== mon_exp.sop ||
                            out_if.eop !== mon_exp.eop) begin
                            errors++;
                            $display("FAIL out_beat: got d=%h s=%b e=%b, want d=%h s=%b e=%b",
                                     out_if.data, out_if.sop, out_if.eop,
                                     mon_exp.data, mon_exp.sop, mon_exp.eop);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held    = '{out_if.data, out_if.sop, out_if.eop};
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_beat(input logic [11:0] d, input logic sop, input logic eop,
                             input bit fwd, input logic exp_eop);
        int    n;
        beat_t e;
        n = 0;
        in_if.data  = d;
        in_if.sop   = sop;
        in_if.eop   = eop;
        in_if.valid = 1'b1;
        if (sop) begin
            tb_eff = effect_sel;
            tb_thr = threshold;
        end
        if (fwd) begin
            e.data = model_fx(d, tb_eff, tb_thr);
            e.sop  = sop;
            e.eop  = exp_eop;
            exp_q.push_back(e);
            if (exp_eop) exp_frames++;
        end
        do begin
            @(negedge clk);
            n++;
        end while (in_if.ready !== 1'b1 && n < 200);
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, want 1", in_if.ready, n);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.data  = 12'h000;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, want 0", out_if.valid);
        end
        checks++;
        if (frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_error: got %b, want 0", frame_error);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d, want 0", frame_count);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", in_if.ready);
        end
    endtask

    task automatic test_pass_invert();
        effect_sel = 2'd1;
        send_beat(12'h123, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, want 0",
                     out_if.valid);
        end
        send_beat(12'h123, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_if.valid !== 1'b1 || out_if.sop !== 1'b1 || out_if.data !== 12'hEDC) begin
            errors++;
            $display("FAIL latency_first: got v=%b s=%b d=%h two cycles after accept, want 1 1 edc",
                     out_if.valid, out_if.sop, out_if.data);
        end
        for (int i = 2; i < 16; i++) send_beat(12'h123, 1'b0, i == 15, 1'b1, i == 15);
        effect_sel = 2'd0;
        for (int i = 0; i < 16; i++) send_beat(12'(i * 37 + 5), i == 0, i == 15, 1'b1, i == 15);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL invert_drain: got %0d beats pending, want 0", exp_q.size());
        end
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL invert_frame_count: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_grey_thresh();
        effect_sel = 2'd2;
        for (int i = 0; i < 16; i++)
            send_beat(i[0] ? 12'hFFF : 12'hF00, i == 0, i == 15, 1'b1, i == 15);
        effect_sel = 2'd3;
        threshold  = 4'd8;
        for (int i = 0; i < 16; i++)
            send_beat(i[0] ? 12'h777 : 12'h888, i == 0, i == 15, 1'b1, i == 15);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grey_drain: got %0d beats pending, want 0", exp_q.size());
        end
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL grey_frame_count: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        int b0;
        b0         = out_beats;
        bp_en      = 1'b1;
        effect_sel = 2'd1;
        for (int i = 0; i < 16; i++)
            send_beat(12'($urandom_range(0, 4095)), i == 0, i == 15, 1'b1, i == 15);
        wait_drain();
        bp_en = 1'b0;
        wait_drain();
        checks++;
        if (out_beats - b0 != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats (%0d pending), want 16 (0 pending)",
                     out_beats - b0, exp_q.size());
        end
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL bp_frame_count: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_short_frame();
        int b0;
        b0         = out_beats;
        err_cycles = 0;
        effect_sel = 2'd0;
        for (int i = 0; i < 11; i++) send_beat(12'(100 + i), i == 0, i == 10, 1'b1, i == 10);
        wait_drain();
        checks++;
        if (err_cycles != (Chk ? 1 : 0)) begin
            errors++;
            $display("FAIL short_error: got %0d error cycles, want %0d", err_cycles, Chk ? 1 : 0);
        end
        checks++;
        if (out_beats - b0 != 11 || frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL short_beats: got %0d beats count=%0d, want 11 count=%0d",
                     out_beats - b0, frame_count, exp_frames);
        end
        err_cycles = 0;
        for (int i = 0; i < 16; i++) send_beat(12'(200 + i), i == 0, i == 15, 1'b1, i == 15);
        wait_drain();
        checks++;
        if (err_cycles != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_next_clean: got %0d error cycles %0d pending, want 0 0",
                     err_cycles, exp_q.size());
        end
    endtask

    task automatic test_long_frame();
        err_cycles = 0;
        effect_sel = 2'd1;
        for (int i = 0; i < 16; i++)
            send_beat(12'(i * 255), i == 0, 1'b0, 1'b1, (i == 15) && Chk);
        wait_drain();
        checks++;
        if (err_cycles != (Chk ? 1 : 0) || frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL long_frame: got err=%0d count=%0d, want err=%0d count=%0d",
                     err_cycles, frame_count, Chk ? 1 : 0, exp_frames);
        end
    endtask

    task automatic test_stray_beat();
        int b0;
        b0         = out_beats;
        err_cycles = 0;
        send_beat(12'hABC, 1'b0, 1'b0, !Chk, 1'b0);
        wait_drain();
        checks++;
        if (err_cycles != (Chk ? 1 : 0) || out_beats - b0 != (Chk ? 0 : 1)) begin
            errors++;
            $display("FAIL stray_beat: got err=%0d beats=%0d, want err=%0d beats=%0d",
                     err_cycles, out_beats - b0, Chk ? 1 : 0, Chk ? 0 : 1);
        end
    endtask

    task automatic test_mode_change();
        err_cycles = 0;
        effect_sel = 2'd1;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) effect_sel = 2'd0;
            send_beat(12'(i * 111 + 7), i == 0, i == 15, 1'b1, i == 15);
        end
        for (int i = 0; i < 16; i++) send_beat(12'(i * 13 + 1), i == 0, i == 15, 1'b1, i == 15);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || err_cycles != 0) begin
            errors++;
            $display("FAIL mode_change: got %0d pending err=%0d, want 0 0", exp_q.size(), err_cycles);
        end
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL mode_frame_count: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pass_invert();
        test_grey_thresh();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_stray_beat();
        test_mode_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
